traffic_signal_monitor: RTL and testbench

- Passive observer on the lamp outputs (Ra,Ya,Ga,Rb,Yb,Gb) and the sensor input sb of the 2-way traffic controller.
- Decodes the lamp pattern back into a phase code, checks lamp legality, sequence order and yellow dwell time, and counts completed signal cycles.
- Sits beside the controller in the top level and in the bench. It has no effect on the controller.

---
 rtl/traffic_signal_monitor.sv | 87 ++++++++
 tb/tb_traffic_signal_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor: passive lamp/phase checker; optional sensor check via TRAFFIC_MON_SENSOR_CHECK_EN
module traffic_signal_monitor #(
  parameter int MIN_YEL = 2,
  parameter int MAX_YEL = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Ra,
  input  logic             Ya,
  input  logic             Ga,
  input  logic             Rb,
  input  logic             Yb,
  input  logic             Gb,
  input  logic             sb,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_vld,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_yel_short,
  output logic             err_yel_long,
  output logic [2:0]       err_code,
  output logic [7:0]       dwell,
  output logic [CNT_W-1:0] cycle_cnt
);
  localparam logic [0:0] IDLE = 1'b0, TRACK = 1'b1;
  localparam logic [7:0] MIN_D = 8'(MIN_YEL), MAX_D = 8'(MAX_YEL);
  logic [0:0] state;
  logic [5:0] lamps;
  logic [1:0] p;
  logic legal, tracking, same, nxt, wrap;
  logic ev_ill, ev_seq, ev_short, ev_long, ev_sens;
  logic [2:0] code_base, first;
  always_comb begin
    lamps = {Ra, Ya, Ga, Rb, Yb, Gb};
    legal = lamps inside {6'b001100, 6'b010100, 6'b100001, 6'b100010};
    p = lamps == 6'b010100 ? 2'd1 : lamps == 6'b100001 ? 2'd2 : lamps == 6'b100010 ? 2'd3 : 2'd0;
    tracking = legal && state == TRACK;
    same = p == phase;
    nxt = p == phase + 2'd1;
    wrap = tracking && phase == 2'd3 && p == 2'd0;
    ev_ill = !legal;
    ev_seq = tracking && !same && !nxt;
    ev_short = tracking && !same && phase[0] && dwell < MIN_D;
    ev_long = tracking && same && phase[0] && dwell == MAX_D;
    code_base = clr_err ? 3'd0 : err_code;
    first = ev_ill ? 3'd1 : ev_seq ? 3'd2 : ev_short ? 3'd3 : ev_long ? 3'd4 : ev_sens ? 3'd5 : 3'd0;
  end
`ifdef TRAFFIC_MON_SENSOR_CHECK_EN
  logic sb_q;
  always_ff @(posedge clk) sb_q <= sb;
  // green may only yield to yellow when the sensor asked for it (A) or stopped asking (B)
  assign ev_sens = tracking && nxt && ((phase == 2'd0 && !sb_q) || (phase == 2'd2 && sb_q));
`else
  logic unused_sb;
  assign unused_sb = sb;
  assign ev_sens = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 2'd0;
      phase_vld <= 1'b0;
      err_illegal <= 1'b0;
      err_seq <= 1'b0;
      err_yel_short <= 1'b0;
      err_yel_long <= 1'b0;
      err_code <= 3'd0;
      dwell <= 8'd0;
      cycle_cnt <= '0;
    end else begin
      phase_vld <= legal;
      if (legal) begin
        state <= TRACK;
        phase <= p;
        dwell <= (tracking && same) ? (dwell == 8'hff ? dwell : dwell + 8'd1) : 8'd1;
      end
      cycle_cnt <= cycle_cnt + CNT_W'(wrap);
      err_illegal <= (err_illegal & ~clr_err) | ev_ill;
      err_seq <= (err_seq & ~clr_err) | ev_seq | ev_sens;
      err_yel_short <= (err_yel_short & ~clr_err) | ev_short;
      err_yel_long <= (err_yel_long & ~clr_err) | ev_long;
      err_code <= code_base != 3'd0 ? code_base : first;
    end
  end
endmodule

// File: tb/tb_traffic_signal_monitor.sv
// tb_traffic_signal_monitor: scoreboard bench comparing the monitor against a phase-level reference model
module tb_traffic_signal_monitor;
  localparam int MIN_YEL = 2;
  localparam int MAX_YEL = 15;
  localparam int CNT_W = 4;
  localparam logic [5:0] G0 = 6'b001100, Y0 = 6'b010100, G1 = 6'b100001, Y1 = 6'b100010, ILL = 6'b001001;

  typedef struct packed {
    logic [1:0] phase;
    logic vld, ei, es, esh, el;
    logic [2:0] code;
    logic [7:0] dwell;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 0, rst = 0, Ra = 0, Ya = 0, Ga = 0, Rb = 0, Yb = 0, Gb = 0, sb = 0, clr_err = 0;
  logic [1:0] phase;
  logic phase_vld, err_illegal, err_seq, err_yel_short, err_yel_long;
  logic [2:0] err_code;
  logic [7:0] dwell;
  logic [CNT_W-1:0] cycle_cnt;

  traffic_signal_monitor #(.MIN_YEL(MIN_YEL), .MAX_YEL(MAX_YEL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Ra(Ra), .Ya(Ya), .Ga(Ga), .Rb(Rb), .Yb(Yb), .Gb(Gb), .sb(sb),
    .clr_err(clr_err), .phase(phase), .phase_vld(phase_vld), .err_illegal(err_illegal),
    .err_seq(err_seq), .err_yel_short(err_yel_short), .err_yel_long(err_yel_long),
    .err_code(err_code), .dwell(dwell), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  exp_t q[$];
  logic [5:0] lamp_of [4] = '{G0, Y0, G1, Y1};

  // reference model: last legal phase (-1 = none yet), visit length, completed cycles, first error
  int m_last = -1, m_dwell = 0, m_code = 0;
  int unsigned m_cnt = 0;
  bit m_vld = 0, f_ill = 0, f_seq = 0, f_sh = 0, f_lg = 0, m_sbp = 0;

  function automatic int decode(logic [5:0] l);
    for (int i = 0; i < 4; i++) if (l == lamp_of[i]) return i;
    return -1;
  endfunction

  function automatic void model(bit r, logic [5:0] l, bit s, bit c);
    int p;
    bit [5:1] ev;
    p = decode(l);
    ev = '0;
    if (r) begin
      m_last = -1; m_dwell = 0; m_cnt = 0; m_vld = 0; m_code = 0;
      {f_ill, f_seq, f_sh, f_lg} = '0;
      m_sbp = s;
      return;
    end
    m_vld = p >= 0;
    if (p < 0) ev[1] = 1;
    else if (m_last < 0) begin
      m_last = p; m_dwell = 1;
    end else if (p == m_last) begin
      if (m_last % 2 == 1 && m_dwell + 1 == MAX_YEL + 1) ev[4] = 1;
      m_dwell = m_dwell < 255 ? m_dwell + 1 : 255;
    end else begin
      if (m_last % 2 == 1 && m_dwell < MIN_YEL) ev[3] = 1;
      if (p != (m_last + 1) % 4) ev[2] = 1;
`ifdef TRAFFIC_MON_SENSOR_CHECK_EN
      else if ((m_last == 0 && !m_sbp) || (m_last == 2 && m_sbp)) ev[5] = 1;
`endif
      if (m_last == 3 && p == 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_last = p; m_dwell = 1;
    end
    if (c) begin
      {f_ill, f_seq, f_sh, f_lg} = '0;
      m_code = 0;
    end
    f_ill |= ev[1]; f_seq |= ev[2] | ev[5]; f_sh |= ev[3]; f_lg |= ev[4];
    if (m_code == 0)
      for (int k = 1; k <= 5; k++) if (ev[k]) begin m_code = k; break; end
    m_sbp = s;
  endfunction

  task automatic step(input bit r, input logic [5:0] l, input bit s, input bit c);
    exp_t e;
    @(negedge clk);
    rst = r; {Ra, Ya, Ga, Rb, Yb, Gb} = l; sb = s; clr_err = c;
    model(r, l, s, c);
    e.phase = m_last < 0 ? 2'd0 : 2'(m_last);
    e.vld = m_vld; e.ei = f_ill; e.es = f_seq; e.esh = f_sh; e.el = f_lg;
    e.code = 3'(m_code); e.dwell = 8'(m_dwell); e.cnt = CNT_W'(m_cnt);
    q.push_back(e);
  endtask

  task automatic hold(input logic [5:0] l, input int n, input bit s);
    for (int i = 0; i < n; i++) step(0, l, s, 0);
  endtask

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("phase", phase, e.phase);
      chk("phase_vld", phase_vld, e.vld);
      chk("err_illegal", err_illegal, e.ei);
      chk("err_seq", err_seq, e.es);
      chk("err_yel_short", err_yel_short, e.esh);
      chk("err_yel_long", err_yel_long, e.el);
      chk("err_code", err_code, e.code);
      chk("dwell", dwell, e.dwell);
      chk("cycle_cnt", cycle_cnt, e.cnt);
    end
  end

  task automatic random_run(input int n, input int stay_pct);
    int gp, r;
    bit s;
    gp = $urandom_range(0, 3);
    s = 0;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 9) == 0) s = ~s;
      if (r < 8) step(1, lamp_of[gp], s, 0);
      else if (r < 50) step(0, 6'($urandom), s, 0);
      else if (r < 90) begin gp = $urandom_range(0, 3); step(0, lamp_of[gp], s, 0); end
      else begin
        if ($urandom_range(0, 99) >= stay_pct) gp = (gp + 1) % 4;
        step(0, lamp_of[gp], s, $urandom_range(0, 29) == 0);
      end
    end
  endtask

  initial begin
    step(1, G0, 0, 0);
    step(1, G0, 0, 0);
    hold(G0, 5, 1);
    hold(Y0, 3, 1);
    hold(G1, 4, 0);
    hold(Y1, 3, 0);
    hold(G0, 2, 1);
    hold(ILL, 1, 1);
    hold(G0, 2, 1);
    hold(G1, 3, 0);
    step(0, G1, 0, 1);
    hold(G1, 1, 0);
    hold(Y1, 1, 0);
    hold(G0, 2, 1);
    step(0, G0, 1, 1);
    hold(Y0, 17, 1);
    hold(G1, 2, 0);
    step(0, G1, 0, 1);
    hold(Y1, 3, 0);
    step(0, G0, 0, 1);
    hold(G0, 2, 0);
    hold(Y0, 2, 0);
    for (int i = 0; i < 20; i++) begin
      hold(G0, 1, 1); hold(Y0, 2, 1); hold(G1, 1, 0); hold(Y1, 2, 0);
    end
    random_run(1500, 70);
    random_run(1500, 95);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
